// File: rtl/xoodoo_pkg.sv
// ---------------------------------------------------------------------------
// xoodoo_pkg
// Shared constants for the Xoodoo permutation arbiter slice.
//   STATE_W          permutation state width (384 bits)
//   DEFAULT_TIMEOUT  default WAIT abort limit in cycles
//   IDX_W / idx_t    requester index type, wide enough for up to 4 requesters
//   IDLE..RETURN     arbiter FSM encoding
// ---------------------------------------------------------------------------
package xoodoo_pkg;

    localparam int STATE_W         = 384;
    localparam int DEFAULT_TIMEOUT = 32;
    localparam int IDX_W           = 2;

    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RETURN = 2'd3;

endpackage

// File: rtl/xoodoo_perm_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the first set request bit at or
// after ptr, wrapping modulo NREQ.
// Ports:
//   req     in   NREQ   request vector
//   ptr     in   idx_t  highest-priority index (must be < NREQ)
//   onehot  out  NREQ   one-hot winner, zero when no request
//   index   out  idx_t  winner index, zero when no request
//   any     out  1      at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import xoodoo_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  idx_t            ptr,
    output logic [NREQ-1:0] onehot,
    output idx_t            index,
    output logic            any
);

    function automatic int wrap_idx(input int p, input int k);
        return (p + k) % NREQ;
    endfunction

    // Scan from the farthest position back to ptr itself so that the
    // nearest requester, found last, overwrites any earlier candidate.
    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr), k)]) begin
                onehot                          = '0;
                onehot[wrap_idx(int'(ptr), k)]  = 1'b1;
                index                           = idx_t'(wrap_idx(int'(ptr), k));
                any                             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xoodoo_perm_arbiter.sv
// ---------------------------------------------------------------------------
// xoodoo_perm_arbiter
// Shares one Xoodoo permutation core among NREQ requesters. Round-robin
// arbitration, latches the winner's state, pulses perm_start, waits for
// perm_done (or aborts after TIMEOUT cycles) and returns the result with a
// one-cycle done pulse to the winner.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   req              level request per requester, held until done[i]
//   req_state        requester i state in [i*STATE_W +: STATE_W]
//   grant            registered one-hot owner of the core
//   done             one-cycle pulse to the granted requester
//   err              valid with done, 1 = timeout abort
//   result           permuted state, valid while done != 0
//   busy             high whenever the FSM is not IDLE
//   perm_start       one-cycle start pulse to the core
//   perm_state_out   latched state presented to the core
//   perm_done        core completion strobe
//   perm_state_in    permuted state from the core, valid with perm_done
// ---------------------------------------------------------------------------
module xoodoo_perm_arbiter
    import xoodoo_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int STATE_W = xoodoo_pkg::STATE_W,
    parameter int TIMEOUT = xoodoo_pkg::DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*STATE_W-1:0] req_state,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic [STATE_W-1:0]      result,
    output logic                    busy,
    output logic                    perm_start,
    output logic [STATE_W-1:0]      perm_state_out,
    input  logic                    perm_done,
    input  logic [STATE_W-1:0]      perm_state_in
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]      state;
    idx_t            ptr;
    idx_t            win_idx;
    logic [7:0]      cnt;
    logic [NREQ-1:0] pick_onehot;
    idx_t            pick_index;
    logic            pick_any;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .index  (pick_index),
        .any    (pick_any)
    );

    // Main FSM. The state is latched only in IDLE, so later req_state or
    // req changes cannot disturb an operation in flight. In WAIT a core
    // completion takes priority over a coincident timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            ptr            <= '0;
            win_idx        <= '0;
            cnt            <= '0;
            grant          <= '0;
            err            <= 1'b0;
            result         <= '0;
            perm_state_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant          <= pick_onehot;
                        win_idx        <= pick_index;
                        perm_state_out <= req_state[int'(pick_index)*STATE_W +: STATE_W];
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (perm_done) begin
                        result <= perm_state_in;
                        err    <= 1'b0;
                        state  <= RETURN;
                    end else if (cnt == TIMEOUT_LAST) begin
                        result <= perm_state_out;
                        err    <= 1'b1;
                        state  <= RETURN;
                    end
                end
                RETURN: begin
                    ptr   <= (win_idx == idx_t'(NREQ - 1)) ? '0 : idx_t'(win_idx + 1'b1);
                    grant <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded outputs; all are zero in IDLE, which covers the reset state.
    always_comb begin
        perm_start = (state == ISSUE);
        busy       = (state != IDLE);
        done       = (state == RETURN) ? grant : '0;
    end

endmodule
